// File: rtl/pl_hazard_ctrl.sv
// Hazard controller for the 5-stage F/D/E/M/W pipeline: stall/flush, E-stage forwarding, data-memory wait FSM.
// Optional HAZARD_PERF_EN adds saturating memory-wait, load-use and branch-flush cycle counters.
module pl_hazard_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic [1:0] ResultSrcE,
  input  logic [1:0] ResultSrcM,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemWriteM,
  input  logic       PCSrcE,
  input  logic       mem_ready,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic [1:0] dbg_state,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_mem_wait,
  output logic [31:0] perf_loaduse,
  output logic [31:0] perf_flush
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q;
  logic             memreq;
  logic             mem_stall;
  logic             load_use;
  logic             in_err;

  assign memreq    = MemWriteM | (ResultSrcM == 2'b01);
  assign in_err    = (state_q == ERR);
  assign mem_stall = (state_q == MEM_WAIT) | ((state_q == RUN) & memreq & ~mem_ready);
  assign load_use  = (ResultSrcE == 2'b01) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  assign dbg_state = state_q;
  assign mem_err   = mem_err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        cnt_d = '0;
        if (memreq && !mem_ready) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR:     state_d = ERR;
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == ERR) mem_err_q <= 1'b1;
    end
  end

  // M-stage producer outranks W because it holds the younger value.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))      fwd_sel = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs)) fwd_sel = 2'b01;
    else                                                fwd_sel = 2'b00;
  endfunction

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);
    if (!rst_n) begin
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushM    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (in_err) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (mem_stall) begin
      // E is held, so a pending PCSrcE survives until the pipeline moves again.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = load_use;
      StallD = load_use;
      FlushE = load_use | PCSrcE;
      FlushD = PCSrcE;
    end
  end

`ifdef HAZARD_PERF_EN
  logic ev_mem, ev_lu, ev_br;
  assign ev_mem = ~in_err & mem_stall;
  assign ev_lu  = ~in_err & ~mem_stall & load_use;
  assign ev_br  = ~in_err & ~mem_stall & PCSrcE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_mem_wait <= '0;
      perf_loaduse  <= '0;
      perf_flush    <= '0;
    end else begin
      if (ev_mem && (perf_mem_wait != '1)) perf_mem_wait <= perf_mem_wait + 1'b1;
      if (ev_lu && (perf_loaduse != '1))   perf_loaduse  <= perf_loaduse + 1'b1;
      if (ev_br && (perf_flush != '1))     perf_flush    <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Self-checking bench for pl_hazard_ctrl: directed hazard scenarios then randomized traffic vs a cycle model.
// Build with +define+HAZARD_PERF_EN to also check the performance counters.
module tb_pl_hazard_ctrl;
  localparam int TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, ResultSrcM;
  logic       RegWriteM, RegWriteW, MemWriteM, PCSrcE, mem_ready;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushM, FlushW;
  logic [1:0] ForwardAE, ForwardBE, dbg_state;
  logic       mem_err;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_mem_wait, perf_loaduse, perf_flush;
`endif

  pl_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemWriteM(MemWriteM),
    .PCSrcE(PCSrcE), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .dbg_state(dbg_state),
    .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_mem_wait(perf_mem_wait), .perf_loaduse(perf_loaduse), .perf_flush(perf_flush)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [12:0] exp_q[$];

  // reference model: "waiting" flag, number of wait cycles spent, sticky error
  bit     m_wait;
  int     m_waits;
  bit     m_err;
  longint m_pmem, m_plu, m_pbr;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; ResultSrcM = 0; RegWriteM = 0; RegWriteW = 0;
    MemWriteM = 0; PCSrcE = 0; mem_ready = 1;
  endtask

  task automatic drive_rand();
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
    RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    ResultSrcE = 2'($urandom_range(0, 3)); ResultSrcM = 2'($urandom_range(0, 3));
    RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
    MemWriteM = ($urandom_range(0, 3) == 0);
    PCSrcE    = ($urandom_range(0, 3) == 0);
    mem_ready = ($urandom_range(0, 3) != 0);
    rst_n     = ($urandom_range(0, 59) != 0);
  endtask

  // One cycle: predict outputs from the rules, compare mid-cycle, then advance the model.
  task automatic step();
    logic [3:0] e_stall, e_flush;
    logic [1:0] e_fa, e_fb;
    bit memreq, mstall, lu, ev_mem, ev_lu, ev_br;
    logic [12:0] e_vec, got;
    memreq = MemWriteM || (ResultSrcM == 2'b01);
    mstall = m_wait || (memreq && !mem_ready);
    lu     = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    ev_mem = 0; ev_lu = 0; ev_br = 0;
    e_fa = ref_fwd(Rs1E);
    e_fb = ref_fwd(Rs2E);
    if (!rst_n) begin
      e_stall = 4'b0000; e_flush = 4'b1111; e_fa = 2'b00; e_fb = 2'b00;
    end else if (m_err) begin
      e_stall = 4'b1111; e_flush = 4'b0000;
    end else if (mstall) begin
      e_stall = 4'b1111; e_flush = 4'b0001; ev_mem = 1;
    end else begin
      e_stall = {lu, lu, 2'b00};
      e_flush = {PCSrcE, lu || PCSrcE, 2'b00};
      ev_lu = lu; ev_br = PCSrcE;
    end
    exp_q.push_back({e_stall, e_flush, e_fa, e_fb, m_err});
    @(negedge clk);
    got   = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
             ForwardAE, ForwardBE, mem_err};
    e_vec = exp_q.pop_front();
    check_eq("stall", 32'(got[12:9]), 32'(e_vec[12:9]));
    check_eq("flush", 32'(got[8:5]),  32'(e_vec[8:5]));
    check_eq("fwdA",  32'(got[4:3]),  32'(e_vec[4:3]));
    check_eq("fwdB",  32'(got[2:1]),  32'(e_vec[2:1]));
    check_eq("mem_err", 32'(got[0]),  32'(e_vec[0]));
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_waits = 0; m_err = 0; m_pmem = 0; m_plu = 0; m_pbr = 0;
    end else begin
      if (ev_mem && m_pmem < 64'hFFFF_FFFF) m_pmem++;
      if (ev_lu  && m_plu  < 64'hFFFF_FFFF) m_plu++;
      if (ev_br  && m_pbr  < 64'hFFFF_FFFF) m_pbr++;
      if (!m_err) begin
        if (m_wait) begin
          m_waits++;
          if (mem_ready) begin m_wait = 0; m_waits = 0; end
          else if (m_waits == TIMEOUT) begin m_wait = 0; m_waits = 0; m_err = 1; end
        end else if (memreq && !mem_ready) begin
          m_wait = 1; m_waits = 0;
        end
      end
    end
    #1;
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZARD_PERF_EN
    check_eq({tag, "_mem"}, perf_mem_wait, 32'(m_pmem));
    check_eq({tag, "_lu"},  perf_loaduse,  32'(m_plu));
    check_eq({tag, "_br"},  perf_flush,    32'(m_pbr));
`endif
  endtask

  initial begin
    m_wait = 0; m_waits = 0; m_err = 0; m_pmem = 0; m_plu = 0; m_pbr = 0;
    drive_idle();
    rst_n = 0;
    #1;
    // reset held two cycles
    step();
    check_eq("rst_flushM", 32'(FlushM), 32'd1);
    step();
    rst_n = 1;
    #1;
    check_eq("run_flushes", 32'({FlushD, FlushE, FlushM, FlushW}), 32'd0);
    step(); step();

    // load-use on rs2, then x0 never stalls
    ResultSrcE = 2'b01; RdE = 5; Rs2D = 5;
    #1;
    check_eq("lu_stall", 32'({StallF, StallD, FlushE}), 32'b111);
    step();
    RdE = 0; Rs1D = 0; Rs2D = 0;
    #1;
    check_eq("lu_x0", 32'({StallF, StallD, FlushE}), 32'b000);
    step();
    drive_idle();

    // forwarding priority
    RdM = 7; RdW = 7; Rs1E = 7; RegWriteM = 1; RegWriteW = 1;
    #1; check_eq("fwd_m", 32'(ForwardAE), 32'b10); step();
    RegWriteM = 0;
    #1; check_eq("fwd_w", 32'(ForwardAE), 32'b01); step();
    Rs1E = 0;
    #1; check_eq("fwd_x0", 32'(ForwardAE), 32'b00); step();
    drive_idle();

    // memory wait with pending branch
    MemWriteM = 1; mem_ready = 0; PCSrcE = 1;
    repeat (3) step();
    mem_ready = 1;
    step();
    MemWriteM = 0;
    #1;
    check_eq("br_after_wait", 32'({FlushD, FlushE}), 32'b11);
    step();
    drive_idle();
    step();
    check_perf("perf_a");

    // timeout into ERR, sticky until reset
    MemWriteM = 1; mem_ready = 0;
    repeat (TIMEOUT) step();
    check_eq("err_not_yet", 32'(mem_err), 32'd0);
    step();
    check_eq("err_set", 32'(mem_err), 32'd1);
    mem_ready = 1; MemWriteM = 0;
    repeat (2) step();
    check_eq("err_sticky", 32'(mem_err), 32'd1);
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
    check_eq("err_cleared", 32'(mem_err), 32'd0);
    step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
    end
    check_perf("perf_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
